// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small byte FIFO: 8N1 frames, LSB first, CLKS_PER_BIT clocks per bit.
// Pushes while full are dropped and latch a sticky overflow flag.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] data,
  output logic       tx,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       overflow
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [15:0]   BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d, ovf_q;
  logic          push, pop, fifo_empty, baud_end;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH);
  // Full is judged on pre-edge state, so a same-edge pop never rescues a push.
  assign push       = send & ~fifo_full;
  assign baud_end   = (baud_q == BAUD_MAX);
  assign tx         = tx_q;
  assign tx_busy    = (state_q != IDLE) | ~fifo_empty;
  assign overflow   = ovf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = START;
      START:   if (baud_end) state_d = DATA;
      DATA:    if (baud_end && bit_q == 3'd7) state_d = STOP;
      STOP:    if (baud_end) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // tx_d is the level for the next cycle, so tx comes straight off a flop.
  always_comb begin
    pop     = 1'b0;
    baud_d  = baud_end ? '0 : baud_q + 16'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
        end
      end
      START: if (baud_end) tx_d = shreg_q[0];
      DATA: if (baud_end) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) tx_d = 1'b1;
        else begin
          shreg_d = {1'b0, shreg_q[7:1]};
          tx_d    = shreg_q[1];
        end
      end
      STOP: if (baud_end) begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
        end else tx_d = 1'b1;
      end
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      if (send && fifo_full) ovf_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (CLKS_PER_BIT=4, FIFO_DEPTH=4) with a serial-line frame monitor.
module tb_uart_tx_fifo;
  localparam int CPB = 4;
  localparam int FL  = 10 * CPB;

  logic clk = 1'b0, reset = 1'b0, send = 1'b0;
  logic [7:0] data = 8'h00;
  logic tx, tx_busy, fifo_full, overflow;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .send(send), .data(data),
    .tx(tx), .tx_busy(tx_busy), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int push_cyc = 0, first_push = 0;
  logic fb [8];
  logic [7:0] rx_q [$];
  int start_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] qb(input int i);
    return (i < rx_q.size()) ? {8'h00, rx_q[i]} : 16'hDEAD;
  endfunction

  function automatic int sq(input int i);
    return (i < start_q.size()) ? start_q[i] : -1000;
  endfunction

  // Frame monitor: samples tx once per cycle, checks 8N1 shape and per-bit hold.
  initial begin
    logic       act;
    int         n;
    logic [FL-1:0] bits;
    logic [7:0] b;
    logic       ok, e;
    act = 1'b0; n = 0; bits = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        act = 1'b0; n = 0;
      end else if (!act) begin
        if (tx === 1'b0) begin
          act = 1'b1; bits[0] = tx; n = 1; start_q.push_back(cyc);
        end
      end else begin
        bits[n] = tx; n++;
        if (n == FL) begin
          act = 1'b0; ok = 1'b1;
          for (int k = 0; k < 8; k++) b[k] = bits[(k + 1) * CPB];
          for (int i = 0; i < FL; i++) begin
            if (i / CPB == 0)      e = 1'b0;
            else if (i / CPB == 9) e = 1'b1;
            else                   e = b[i / CPB - 1];
            if (bits[i] !== e) ok = 1'b0;
          end
          chk("frame_fmt", {63'd0, ok}, 64'd1);
          rx_q.push_back(b);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0; send = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    rx_q.delete(); start_q.delete();
  endtask

  // n consecutive sends of first, first+step, ...; fb[i] is fifo_full just before edge i.
  task automatic push_seq(input int n, input logic [7:0] first, input logic [7:0] step);
    @(posedge clk); #1;
    send = 1'b1;
    for (int i = 0; i < n; i++) begin
      data  = 8'(first + 8'(i) * step);
      fb[i] = fifo_full;
      @(posedge clk); #1;
      if (i == 0) push_cyc = cyc;
    end
    send = 1'b0; data = 8'hEE;
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
    @(negedge clk);
    chk(tag, 64'(rx_q.size() >= n), 64'd1);
  endtask

  initial begin
    int zeros;
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx, 1); chk("rst_busy", tx_busy, 0);
    chk("rst_full", fifo_full, 0); chk("rst_ovf", overflow, 0);
    reset = 1'b1;

    // single byte 0xA5
    push_seq(1, 8'hA5, 8'h00);
    chk("nobypass_tx", tx, 1); chk("busy_queued", tx_busy, 1);
    repeat (FL) @(posedge clk);
    @(negedge clk); chk("busy_in_stop", tx_busy, 1);
    @(negedge clk); chk("idle_tx", tx, 1); chk("idle_busy", tx_busy, 0);
    chk("a5_byte", qb(0), 16'h00A5); chk("a5_count", rx_q.size(), 1);
    chk("a5_latency", 64'(sq(0) - push_cyc), 64'd1);

    // back-to-back 0x00, 0xFF
    rx_q.delete(); start_q.delete();
    push_seq(2, 8'h00, 8'hFF);
    wait_frames("b2b_wait", 2, 200);
    chk("b2b_b0", qb(0), 16'h0000); chk("b2b_b1", qb(1), 16'h00FF);
    chk("b2b_latency", 64'(sq(0) - push_cyc), 64'd1);
    chk("b2b_gap", 64'(sq(1) - sq(0)), 64'(FL));
    repeat (5) @(negedge clk);

    // overflow: six sends into a 4-deep FIFO
    rx_q.delete(); start_q.delete();
    push_seq(6, 8'h11, 8'h11);
    chk("ovf_notfull_e4", fb[4], 0); chk("ovf_full_e5", fb[5], 1);
    chk("ovf_set", overflow, 1);
    wait_frames("ovf_wait", 5, 400);
    for (int i = 0; i < 5; i++) chk($sformatf("ovf_b%0d", i), qb(i), 16'(8'h11 * (i + 1)));
    repeat (60) @(negedge clk);
    chk("ovf_nframes", rx_q.size(), 5); chk("ovf_sticky", overflow, 1);

    // full FIFO plus send on the popping STOP-end edge
    do_reset();
    chk("ovf_cleared", overflow, 0);
    push_seq(5, 8'h31, 8'h01);
    repeat (36) @(posedge clk);
    #1 send = 1'b1; data = 8'h77;
    chk("fp_full_before", fifo_full, 1); chk("fp_ovf_before", overflow, 0);
    @(posedge clk); #1;
    chk("fp_full_after_pop", fifo_full, 0); chk("fp_ovf_after", overflow, 1);
    data = 8'h88;
    @(posedge clk); #1;
    send = 1'b0; data = 8'hEE;
    chk("fp_full_refill", fifo_full, 1);
    wait_frames("fp_wait", 6, 500);
    chk("fp_b0", qb(0), 16'h0031); chk("fp_b1", qb(1), 16'h0032);
    chk("fp_b2", qb(2), 16'h0033); chk("fp_b3", qb(3), 16'h0034);
    chk("fp_b4", qb(4), 16'h0035); chk("fp_b5", qb(5), 16'h0088);

    // reset during data bit 3 of 0xC3 with two bytes queued
    do_reset();
    push_seq(3, 8'hC3, 8'h10);
    repeat (16) @(posedge clk);
    #2 chk("mid_bit3", tx, 0); chk("mid_busy", tx_busy, 1);
    #1 reset = 1'b0;
    #1 chk("arst_tx", tx, 1); chk("arst_busy", tx_busy, 0);
    chk("arst_full", fifo_full, 0); chk("arst_ovf", overflow, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    rx_q.delete(); start_q.delete();
    zeros = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) zeros++;
    end
    chk("post_rst_idle", zeros, 0); chk("post_rst_frames", rx_q.size(), 0);
    chk("post_rst_busy", tx_busy, 0);

    // send on first edge after release, then ten spaced sends wrapping the pointers
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    rx_q.delete(); start_q.delete();
    send = 1'b1; data = 8'h01;
    @(posedge clk); #1;
    first_push = cyc; send = 1'b0; data = 8'hEE;
    for (int i = 1; i < 10; i++) begin
      repeat (48) @(posedge clk);
      push_seq(1, 8'(i + 1), 8'h00);
    end
    wait_frames("wrap_wait", 10, 200);
    chk("first_edge_latency", 64'(sq(0) - first_push), 64'd1);
    for (int i = 0; i < 10; i++) chk($sformatf("wrap_b%0d", i), qb(i), 16'(i + 1));
    chk("wrap_ovf", overflow, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of byte entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port send  input  1  request to queue data; sampled every rising edge; driven directly from the control FSM's uart_send.
REQ-006 SHALL have port data  input  8  byte to queue (accumulator value) when send=1.
REQ-007 SHALL have port tx  output  1  serial line, idle high.
REQ-008 SHALL have port tx_busy  output  1  high while a frame is in progress or the FIFO is non-empty.
REQ-009 SHALL have port fifo_full  output  1  high when the FIFO holds FIFO_DEPTH entries.
REQ-010 SHALL have port overflow  output  1  sticky flag: a send was dropped.

Function
REQ-011 SHALL accept a push on any edge where send=1 and fifo_full=0, writing data at the tail.
REQ-012 SHALL drop a push on an edge where send=1 and fifo_full=1, as evaluated before that edge, even if a pop occurs on the same edge, and SHALL set overflow=1.
REQ-013 SHALL clear overflow only by reset.
REQ-014 SHALL use a transmit FSM with states IDLE, START, DATA, STOP.
REQ-015 In IDLE with the FIFO non-empty, SHALL pop the head into an 8-bit shift register and enter START on the same edge; in IDLE with the FIFO empty, SHALL remain in IDLE with tx=1.
REQ-016 SHALL have no bypass path: a byte pushed at edge E into an empty FIFO is popped at edge E+1, and tx=0 from edge E+1.
REQ-017 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-018 DATA SHALL drive the 8 bits LSB first, each for exactly CLKS_PER_BIT cycles, tracked with a 3-bit bit index, then enter STOP.
REQ-019 STOP SHALL drive tx=1 for exactly CLKS_PER_BIT cycles.
REQ-020 At the end of STOP with the FIFO non-empty, SHALL pop and enter START on the same edge, giving no idle gap; with the FIFO empty, SHALL enter IDLE.
REQ-021 Each frame SHALL be exactly 10*CLKS_PER_BIT cycles; the baud counter SHALL reload to 0 at each bit boundary and wrap at CLKS_PER_BIT-1.
REQ-022 SHALL hold the FIFO read/write pointers modulo FIFO_DEPTH, with wrap-around, and an occupancy count of width log2(FIFO_DEPTH)+1.
REQ-023 On simultaneous push and pop with 0<count<FIFO_DEPTH, count SHALL be unchanged and both pointers SHALL advance.
REQ-024 tx SHALL be driven from a register (glitch-free); fifo_full and tx_busy MAY be combinational from registered state.
REQ-025 Changes to data while send=0 SHALL have no effect.

Reset
REQ-026 reset=0 SHALL immediately force: state IDLE, tx=1, FIFO empty, pointers and count 0, baud counter 0, bit index 0, shift register 0x00, tx_busy=0, fifo_full=0, overflow=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame; queued bytes SHALL be discarded, and tx SHALL be 1 with no partial byte resumed after release.
REQ-028 After reset deasserts, the first rising edge SHALL operate normally (a send on that edge is accepted).

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-029 Single byte: send=1, data=0xA5 for one cycle -> from the next edge tx = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; then tx=1 and tx_busy=0 after 40 cycles.
REQ-030 Back-to-back: sends 0x00 then 0xFF on consecutive cycles -> two 40-cycle frames with no idle cycle between the first stop bit and the second start bit.
REQ-031 Overflow: sends 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 on consecutive cycles -> frames 0x11, 0x22, 0x33, 0x44, 0x55 are transmitted; 0x66 is dropped (fifo_full was 1 before that edge); overflow=1 and stays 1 until reset.
REQ-032 Full plus pop: FIFO full and send=1 on the STOP-end edge that pops -> the push is dropped, count becomes 3, and overflow=1.
REQ-033 Reset mid-frame: assert reset during bit 3 of 0xC3 with 2 bytes queued -> tx=1 immediately and tx_busy=0; after release with no sends, tx stays 1 for 100 cycles.
REQ-034 Pointer wrap: 10 single sends of 0x01..0x0A, spaced 50 cycles apart -> all 10 bytes are transmitted in order and overflow=0.
